// File: rtl/aes_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_cmd_ctrl
// Description : Command sequencer in front of aes_top. Accepts key-expand,
//               encrypt and decrypt commands on a valid/ready stream, starts
//               the engine, waits for completion (with a watchdog) and returns
//               one response beat per command. Tracks key-schedule validity.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_cmd_ctrl #(
  parameter int KEY_S          = 128,
  parameter int BLK_S          = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [KEY_S-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BLK_S-1:0] rsp_data,
  output logic             rsp_err,
  output logic             key_valid,
  output logic             busy,
  output logic             aes_en,
  output logic             aes_cipher_mode,
  output logic             aes_decipher_mode,
  output logic             aes_key_exp_mode,
  output logic [KEY_S-1:0] aes_key,
  output logic [BLK_S-1:0] aes_in_blk,
  input  logic [BLK_S-1:0] aes_out_blk,
  input  logic             aes_en_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_ENC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             key_valid_q, key_valid_d;
  logic [KEY_S-1:0] aes_key_q, aes_key_d;
  logic [BLK_S-1:0] aes_in_blk_q, aes_in_blk_d;
  logic [BLK_S-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= OP_KEY;
      key_valid_q  <= 1'b0;
      aes_key_q    <= '0;
      aes_in_blk_q <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_valid_q  <= key_valid_d;
      aes_key_q    <= aes_key_d;
      aes_in_blk_q <= aes_in_blk_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Next-state logic and engine control outputs.
  always_comb begin
    state_d           = state_q;
    op_d              = op_q;
    key_valid_d       = key_valid_q;
    aes_key_d         = aes_key_q;
    aes_in_blk_d      = aes_in_blk_q;
    rsp_data_d        = rsp_data_q;
    rsp_err_d         = rsp_err_q;
    cnt_d             = cnt_q;
    aes_en            = 1'b0;
    aes_cipher_mode   = 1'b0;
    aes_decipher_mode = 1'b0;
    aes_key_exp_mode  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          case (cmd_op)
            OP_KEY: begin
              aes_key_d   = cmd_data;
              // The old schedule is overwritten from the first engine cycle.
              key_valid_d = 1'b0;
              state_d     = START;
            end
            OP_ENC, OP_DEC: begin
              aes_in_blk_d = cmd_data[BLK_S-1:0];
              if (key_valid_q) begin
                state_d = START;
              end else begin
                rsp_err_d = 1'b1;
                state_d   = RESP;
              end
            end
            default: begin
              rsp_err_d = 1'b1;
              state_d   = RESP;
            end
          endcase
        end
      end

      START: begin
        aes_en  = 1'b1;
        cnt_d   = '0;
        state_d = BUSY;
      end

      BUSY: begin
        // Completion has priority over a watchdog expiring in the same cycle.
        if (aes_en_o) begin
          rsp_data_d = (op_q == OP_KEY) ? '0 : aes_out_blk;
          rsp_err_d  = 1'b0;
          if (op_q == OP_KEY) begin
            key_valid_d = 1'b1;
          end
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Mode lines follow the registered op only while the engine is running.
    if (state_q == START || state_q == BUSY) begin
      aes_key_exp_mode  = (op_q == OP_KEY);
      aes_cipher_mode   = (op_q == OP_ENC);
      aes_decipher_mode = (op_q == OP_DEC);
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign key_valid  = key_valid_q;
  assign aes_key    = aes_key_q;
  assign aes_in_blk = aes_in_blk_q;

endmodule
`default_nettype wire
